bin2bcd_seq: RTL

- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
- Sits directly upstream of the lab's 4-bit seven-segment decoders.
- Takes a binary value (board switches or a counter) and produces one packed BCD nibble per display digit. Nibble n drives the decoder for HEXn.
- Start/done handshake; one bit is processed per clock.

---
 rtl/bin2bcd_pkg.sv | 20 ++
 rtl/bin2bcd_seq_add3.sv | 16 +
 rtl/bin2bcd_seq.sv | 127 ++++++++++++
 3 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam int unsigned BCD_W = 4;

   // True when DIGITS decimal digits can hold every BIN_W-bit value.
   function automatic bit digits_ok(input int unsigned bin_w, input int unsigned digits);
      longint unsigned pow10;
      longint unsigned max_bin;
      pow10   = 1;
      max_bin = (64'd1 << bin_w) - 64'd1;
      for (int unsigned i = 0; i < digits; i++) begin
         pow10 = pow10 * 10;
      end
      return pow10 > max_bin;
   endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more.
module bcd_add3
   import bin2bcd_pkg::*;
(
   input  logic [BCD_W-1:0] digit,
   output logic [BCD_W-1:0] adjusted
);

   always_comb begin
      adjusted = digit;
      if (digit >= BCD_W'(5)) begin
         adjusted = digit + BCD_W'(3);
      end
   end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Optional leading-zero blank mask: define BIN2BCD_LEADING_BLANK_EN.
module bin2bcd_seq
   import bin2bcd_pkg::*;
#(
   parameter int unsigned BIN_W  = 10,
   parameter int unsigned DIGITS = 4
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_start,
   input  logic [BIN_W-1:0]        i_bin,
   output logic                    o_busy,
   output logic                    o_done,
   output logic [BCD_W*DIGITS-1:0] o_bcd,
   output logic [DIGITS-1:0]       o_blank
);

   localparam int unsigned CNT_W  = $clog2(BIN_W + 1);
   localparam int unsigned WORK_W = BCD_W * DIGITS;

   generate
      if (!digits_ok(BIN_W, DIGITS)) begin : g_bad_params
         $error("bin2bcd_seq: DIGITS too small for BIN_W");
      end
   endgenerate

   state_t              state, state_n;
   logic [BIN_W-1:0]    shift_q, shift_n;
   logic [WORK_W-1:0]   work_q, work_n;
   logic [WORK_W-1:0]   adj;
   logic [CNT_W-1:0]    cnt_q, cnt_n;
   logic                load_out;
   logic [DIGITS-1:0]   blank_calc;

   for (genvar g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
         .digit    (work_q[g*BCD_W +: BCD_W]),
         .adjusted (adj[g*BCD_W +: BCD_W])
      );
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Shifts run while the counter is non-zero; the cycle that finds it at zero
   // publishes the result, putting o_done BIN_W+1 edges after the start edge.
   always_comb begin
      state_n  = state;
      shift_n  = shift_q;
      work_n   = work_q;
      cnt_n    = cnt_q;
      load_out = 1'b0;
      case (state)
         IDLE: begin
            if (i_start) begin
               shift_n = i_bin;
               work_n  = '0;
               cnt_n   = CNT_W'(BIN_W);
               state_n = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt_q != '0) begin
               {work_n, shift_n} = {adj, shift_q} << 1;
               cnt_n             = cnt_q - CNT_W'(1);
            end else begin
               load_out = 1'b1;
               state_n  = DONE;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         shift_q <= '0;
         work_q  <= '0;
         cnt_q   <= '0;
      end else begin
         shift_q <= shift_n;
         work_q  <= work_n;
         cnt_q   <= cnt_n;
      end
   end

`ifdef BIN2BCD_LEADING_BLANK_EN
   always_comb begin
      logic zero_above;
      blank_calc = '0;
      zero_above = 1'b1;
      for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
         zero_above    = zero_above & (work_q[i*BCD_W +: BCD_W] == '0);
         blank_calc[i] = zero_above;
      end
   end
`else
   always_comb begin
      blank_calc = '0;
   end
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_bcd   <= '0;
         o_blank <= '0;
      end else if (load_out) begin
         o_bcd   <= work_q;
         o_blank <= blank_calc;
      end
   end

   assign o_busy = (state != IDLE);
   assign o_done = (state == DONE);

endmodule
